// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the 5-stage pipeline stages.
// Contents:
//   occ_state_e      - occupancy-encoded state of a 2-entry skid stage
//   NOP_INST_DEFAULT - default encoding driven on the instruction channel
//                      whenever a stage presents no real entry
//   chan_lsb()       - LSB position of channel k in a packed multi-channel bus
package pipe_pkg;

  // Each state value equals the number of entries held, so the state register
  // can be driven straight onto an occupancy port.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  // Channel k of a bus with WIDTH-bit channels lives at [chan_lsb(k,WIDTH) +: WIDTH].
  function automatic int chan_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter for pipeline statistics (stall/hazard cycles).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears the count
//   inc    - add one this cycle (ignored once the count reaches all-ones)
//   clr    - synchronous clear, wins over inc
//   value  - current count, CNT_W bits
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  // Clear has priority; at all-ones the count sticks instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {CNT_W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/id_skid_stage.sv
// id_skid_stage
// IF/ID pipeline stage with valid/ready handshake, 2-entry skid buffer,
// flush (NOP bubble) insertion and a saturating stall counter.
// Channel 0 carries the instruction, channels 1..NCH-1 the delay-slot PC words.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - fetch presents a word set on in_data
//   in_ready    - registered; low only while both entries are occupied
//   in_data     - NCH*WIDTH payload, channel k at [k*WIDTH +: WIDTH]
//   flush       - drop every held entry (taken branch/jump)
//   out_valid   - out_data holds a real entry
//   out_ready   - decode consumes the entry this cycle
//   out_data    - registered payload; NOP pattern whenever out_valid is low
//   occupancy   - number of entries held (0..2)
//   stall_cnt   - saturating count of cycles with out_valid && !out_ready
//   stall_clr   - synchronous clear of stall_cnt
module id_skid_stage
  import pipe_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          NCH      = 3,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 stall_clr
);

  // NOP_INST is truncated or zero-extended into channel 0; the PC channels are zero.
  localparam logic [WIDTH-1:0]     NOP_CH0 = WIDTH'(NOP_INST);
  localparam logic [NCH*WIDTH-1:0] NOP_PAT = (NCH*WIDTH)'(NOP_CH0);

  occ_state_e           state_q, state_d;
  logic [NCH*WIDTH-1:0] main_q, main_d;
  logic [NCH*WIDTH-1:0] skid_q, skid_d;
  logic                 in_ready_q;
  logic                 in_fire, out_fire;

  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  // main_q is reloaded with the NOP pattern on every transition into EMPTY,
  // so it can drive out_data directly without an output mux.
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_ready  = in_ready_q;

  // Next-state and data-path selection. Flush overrides every other event:
  // a concurrent out_fire has already been taken by decode, and a concurrent
  // in_fire is accepted but thrown away.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_PAT;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_PAT;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_PAT;
          skid_d  = '0;
        end
      endcase
    end
  end

  // in_ready is computed from the next state so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= NOP_PAT;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .clr   (stall_clr),
    .value (stall_cnt)
  );

endmodule

// File: tb/tb_id_skid_stage.sv
// tb_id_skid_stage
// Self-checking bench for id_skid_stage (WIDTH=32, NCH=3, CNT_W=4).
// Accepted payloads are pushed onto a scoreboard queue and popped and compared
// when decode consumes them; a flush empties the queue.
module tb_id_skid_stage;
  import pipe_pkg::*;

  localparam int          WIDTH = 32;
  localparam int          NCH   = 3;
  localparam int          CNT_W = 4;
  localparam int          DW    = NCH * WIDTH;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [DW-1:0] NOP_PAT = DW'(NOP);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic            stall_clr;

  logic [DW-1:0]   mq[$];
  int              expStall;
  int              tests;
  int              failed;

  id_skid_stage #(
    .WIDTH    (WIDTH),
    .NCH      (NCH),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [31:0] x);
    return {x + 32'd2, x + 32'd1, x};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("occupancy", DW'(occupancy), DW'(mq.size()));
    checkOutput("in_ready",  DW'(in_ready),  DW'(mq.size() < 2));
    checkOutput("out_valid", DW'(out_valid), DW'(mq.size() > 0));
    checkOutput("stall_cnt", DW'(stall_cnt), DW'(expStall));
    if (mq.size() == 0) begin
      checkOutput("nop_data", out_data, NOP_PAT);
      checkOutput("nop_ch0", DW'(out_data[chan_lsb(0, WIDTH) +: WIDTH]), DW'(NOP));
    end
  endtask

  // One clock cycle: check the outputs, drive the inputs at the falling edge,
  // then advance the reference queue and stall count across the rising edge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                               input logic fl, input logic clr);
    bit inFire, outFire, stallInc;
    @(negedge clk);
    checkState();
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    inFire   = iv && (mq.size() < 2);
    outFire  = (mq.size() > 0) && ordy;
    stallInc = (mq.size() > 0) && !ordy;
    if (outFire) checkOutput("pop_data", out_data, mq[0]);
    @(posedge clk);
    if (outFire) void'(mq.pop_front());
    if (fl) mq.delete();
    else if (inFire) mq.push_back(d);
    if (clr) expStall = 0;
    else if (stallInc && expStall < (1 << CNT_W) - 1) expStall++;
    #1;
  endtask

  initial begin
    tests = 0; failed = 0; expStall = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    out_ready = 1'b0; stall_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkState();
    rst_n = 1'b1;

    // Streaming at full throughput
    applyStimulus(1'b1, {32'h8, 32'h4, 32'h2000_0001}, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk(32'h100 + i), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure fills the skid, then drains in order
    applyStimulus(1'b1, mk(32'h11), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h22), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h99), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with a full buffer and a concurrent push
    applyStimulus(1'b1, mk(32'h44), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h55), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h33), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush coincident with out_fire
    applyStimulus(1'b1, mk(32'hD0), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Stall counter saturation and clear during a continuing stall
    applyStimulus(1'b1, mk(32'hF0), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Random traffic with occasional flushes
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), mk($urandom), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset with a full buffer
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'hA0), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'hB0), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    mq.delete();
    expStall = 0;
    checkState();
    @(negedge clk);
    checkState();
    rst_n = 1'b1;
    applyStimulus(1'b1, mk(32'hE0), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_skid_stage.md
Name: id_skid_stage

Overview:
- Next-generation IF/ID pipeline stage for the 5-stage pipeline. It replaces the fixed three-word, always-capture IF/ID register.
- Carries NCH payload channels of WIDTH bits each: channel 0 is the instruction; channels 1..NCH-1 are the delay-slot PC words.
- Adds a valid/ready handshake, a 2-entry skid buffer, flush (NOP bubble) insertion and a saturating stall counter.
- Sits between fetch and the decode/regfile logic.

Parameters:
- WIDTH, 32, bits per channel.
- NCH, 3, number of payload channels; minimum 1.
- NOP_INST, 32'h0000_0000, value driven on channel 0 when the output is invalid or flushed; truncated/zero-extended to WIDTH.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a word set.
- in_ready  output  1  stage can accept; registered; equals !skid_full.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- flush  input  1  discard all held entries (branch/jump taken).
- out_valid  output  1  out_data holds a real entry.
- out_ready  input  1  decode consumes this cycle.
- out_data  output  NCH*WIDTH  registered payload.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cnt  output  CNT_W  cycles with out_valid && !out_ready; saturating.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, occupancy=0, in_ready=1, stall_cnt=0.
  - out_data = NOP pattern: channel 0 = NOP_INST, other channels = 0.
  - Skid register cleared. Reset mid-transfer drops all entries; no partial state survives.
- Handshakes: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready. out_data is stable while out_valid && !out_ready.
- States, encoded by occupancy:
  - EMPTY:
    - in_fire -> ONE, main <= in_data.
  - ONE:
    - in_fire && out_fire -> ONE, main <= in_data.
    - in_fire && !out_fire -> TWO, skid <= in_data.
    - !in_fire && out_fire -> EMPTY, main <= NOP pattern.
    - Otherwise hold.
  - TWO (in_ready=0):
    - out_fire -> ONE, main <= skid.
    - Otherwise hold.
- Latency: in_fire in cycle N from EMPTY gives out_valid=1 with the data in cycle N+1. Full throughput is 1 entry per cycle while out_ready=1.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- in_ready next = !(next state == TWO). It is never combinationally dependent on out_ready.
- Flush has priority over all other events:
  - Next state is EMPTY and main <= NOP pattern.
  - An in_fire in the same cycle is consumed and discarded.
  - An out_fire in the same cycle completes normally; the consumer owns that entry.
- Invalid output always shows the NOP pattern. Decode logic without valid awareness therefore sees a harmless instruction.
- stall_cnt:
  - +1 per cycle with out_valid && !out_ready.
  - Holds at 2^CNT_W-1.
  - stall_clr has priority over increment.
  - Flush does not clear it.

Decomposition:
- Shared package pipe_pkg holds:
  - occupancy state constants (ST_EMPTY=0, ST_ONE=1, ST_TWO=2);
  - the default NOP encoding;
  - a channel-slice helper function.
- One natural sub-module: sat_counter (CNT_W, inc, clr, value), reused by later stages for hazard/stall statistics.
- The data path (main/skid registers, NOP muxing) stays in id_skid_stage.

Test Plan:
- Reset then stream: rst_n low 3 cycles, then in_data={32'h8,32'h4,32'h2000_0001} with in_valid=1, out_ready=1 -> out_valid=1 one cycle later with identical data; occupancy=1; in_ready stays 1.
- Backpressure: hold out_ready=0 and push A=32'h11, then B=32'h22 -> occupancy=2, in_ready=0, out_data=A stable. Raise out_ready -> A, then B, in consecutive cycles; in_ready returns to 1 after the first out_fire.
- Flush with full buffer: occupancy=2, pulse flush with in_valid=1 (C=32'h33) -> next cycle out_valid=0, channel 0 = NOP_INST, occupancy=0; C is never output.
- Flush coincident with out_fire: occupancy=1 with entry D, out_ready=1, flush=1 -> D is counted consumed once; next cycle EMPTY; no D replay.
- Stall counter: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15; stall_clr=1 -> 0 next cycle, even if the stall continues that cycle.
- Async reset mid-operation: occupancy=2, drop rst_n between clock edges -> outputs go to reset values immediately, without waiting for a clock edge; after release, the first new input appears with latency 1.
